// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: DATA/STATUS registers, byte FIFO, 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frame).
module uart_tx_port #(
  parameter logic [31:0] BASE      = 32'h4000_0000,
  parameter int          DIVISOR   = 868,
  parameter int          FIFO_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        tx
);

  localparam int                 DEPTH      = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]        BAUD_LOAD  = 16'(DIVISOR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] rd_ptr, wr_ptr;
  logic [FIFO_LOG2:0]   count;
  logic                 overflow;
  logic                 sel_data, sel_status;
  logic                 full, empty, busy;
  logic                 enq_req, enq, deq;
  logic [7:0]           count8;
  logic                 unused_bits;

  state_t      state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n;
`ifdef UART_TX_PARITY_EN
  logic        parity, parity_n;
`endif

  assign sel_data    = (bus_addr == BASE);
  assign sel_status  = (bus_addr == BASE + 32'd1);
  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign busy        = (state != IDLE);
  assign count8      = 8'(count);
  assign unused_bits = ^{bus_data_w[31:8], bus_mask_w[3:1]};

  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign enq_req = sel_data & bus_mask_w[0];
  assign enq     = enq_req & (~full | deq);

  always_comb begin
    bus_data_r = 32'd0;
    if (sel_status)
      bus_data_r = {16'd0, count8, 4'd0, overflow, busy, empty, full};
  end

  always_ff @(posedge clock) begin
    if (enq)
      mem[wr_ptr] <= bus_data_w[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (enq_req && full && !deq)
        overflow <= 1'b1;
      else if (sel_status && bus_mask_w[0] && bus_data_w[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
      parity  <= parity_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    deq       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n  = parity;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          deq     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = BAUD_LOAD;
          state_n = START;
`ifdef UART_TX_PARITY_EN
          parity_n = ^mem[rd_ptr];
`endif
        end
      end
      START: begin
        if (baud == '0) begin
          baud_n    = BAUD_LOAD;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            shift_n   = shift >> 1;
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud == '0) begin
          baud_n  = BAUD_LOAD;
          state_n = STOP;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
`endif
      STOP: begin
        // Back-to-back frames skip the idle cycle by loading the next byte here.
        if (baud == '0) begin
          if (!empty) begin
            deq     = 1'b1;
            shift_n = mem[rd_ptr];
            baud_n  = BAUD_LOAD;
            state_n = START;
`ifdef UART_TX_PARITY_EN
            parity_n = ^mem[rd_ptr];
`endif
          end else begin
            baud_n  = '0;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is registered from the next state so tx never glitches.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at DIVISOR=4: register map, frame shape, FIFO overflow, reset abort.
module tb_uart_tx_port;

  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 44;
`else
  localparam int FRAME = 40;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;
  logic [31:0] bus_data_r;
  logic        tx;

  int total = 0;
  int bad   = 0;

  logic [87:0] exp_q[$];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  uart_tx_port #(.BASE(BASE), .DIVISOR(4), .FIFO_LOG2(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w),
    .bus_data_r (bus_data_r),
    .tx         (tx)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // checking
  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k < 4) return 1'b0;
    if (k < 36) return b[(k - 4) / 4];
`ifdef UART_TX_PARITY_EN
    if (k < 40) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [87:0] exp_frames(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic [87:0] v = '0;
    for (int k = 0; k < FRAME; k++) v[k] = exp_bit(b0, k);
    if (n == 2)
      for (int k = 0; k < FRAME; k++) v[FRAME + k] = exp_bit(b1, k);
    return v;
  endfunction

  // drivers
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clock);
    bus_addr   = addr;
    bus_data_w = data;
    bus_mask_w = mask;
    @(posedge clock);
    #1;
    bus_mask_w = 4'd0;
    bus_addr   = BASE + 32'd1;
  endtask

  task automatic read_status(output logic [31:0] val);
    bus_addr = BASE + 32'd1;
    #1;
    val = bus_data_r;
  endtask

  task automatic capture(input int n, output logic [87:0] cap);
    cap = '0;
    for (int k = 0; k < n; k++) begin
      cap[k] = tx;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [31:0] st;
    logic [87:0] cap;
    int          low_count;

    reset      = 1'b1;
    bus_addr   = 32'd0;
    bus_data_w = 32'd0;
    bus_mask_w = 4'd0;

    vecs[0] = '{32'd0,         32'd0,          4'h0, BASE,          32'd0};
    vecs[1] = '{32'd0,         32'd0,          4'h0, BASE + 32'd1,  32'h2};
    vecs[2] = '{BASE + 32'd2,  32'hFF,         4'hF, BASE + 32'd2,  32'd0};
    vecs[3] = '{32'd0,         32'd0,          4'h0, BASE + 32'd1,  32'h2};
    vecs[4] = '{BASE,          32'hAA,         4'hE, BASE + 32'd1,  32'h2};
    vecs[5] = '{BASE + 32'd1,  32'hFFFF_FFFF,  4'hF, BASE + 32'd1,  32'h2};
    vecs[6] = '{32'd0,         32'd0,          4'h0, 32'd0,         32'd0};
    vecs[7] = '{32'd0,         32'd0,          4'h0, BASE - 32'd1,  32'd0};

    apply_reset();
    #1;
    check("reset_tx", 88'(tx), 88'(1'b1));
    read_status(st);
    check("reset_status", 88'(st), 88'(32'h2));

    // register map vectors (FIFO empty, block idle)
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bus_addr   = vecs[i].waddr;
      bus_data_w = vecs[i].wdata;
      bus_mask_w = vecs[i].wmask;
      @(posedge clock);
      #1;
      bus_mask_w = 4'd0;
      bus_addr   = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d_read", i), 88'(bus_data_r), 88'(vecs[i].exp));
    end

    // single frame 0x55
    bus_write(BASE, 32'h55, 4'h1);
    check("tx_idle_at_write_edge", 88'(tx), 88'(1'b1));
    read_status(st);
    check("status_one_queued", 88'(st), 88'(32'h0000_0100));
    @(posedge clock);
    #1;
    exp_q.push_back(exp_frames(8'h55, 8'h00, 1));
    capture(FRAME, cap);
    check("frame_55", cap, exp_q.pop_front());
    read_status(st);
    check("idle_after_frame_55", 88'(st), 88'(32'h2));

    // two contiguous frames
    bus_write(BASE, 32'h01, 4'h1);
    bus_write(BASE, 32'h02, 4'h1);
    exp_q.push_back(exp_frames(8'h01, 8'h02, 2));
    capture(2 * FRAME, cap);
    check("frames_01_02_contiguous", cap, exp_q.pop_front());
    read_status(st);
    check("idle_after_two_frames", 88'(st), 88'(32'h2));

`ifdef UART_TX_PARITY_EN
    bus_write(BASE, 32'h07, 4'h1);
    @(posedge clock);
    #1;
    exp_q.push_back(exp_frames(8'h07, 8'h00, 1));
    capture(FRAME, cap);
    check("frame_07_parity", cap, exp_q.pop_front());
    check("parity_bit_07", 88'(cap[36]), 88'(1'b1));
    read_status(st);
    check("idle_after_parity_frame", 88'(st), 88'(32'h2));
`endif

    // overflow: one byte in flight, then 17 writes
    bus_write(BASE, 32'h00, 4'h1);
    for (int i = 0; i < 16; i++) bus_write(BASE, 32'(i + 1), 4'h1);
    read_status(st);
    check("status_full_no_overflow", 88'(st), 88'(32'h0000_1005));
    bus_write(BASE, 32'hEE, 4'h1);
    read_status(st);
    check("status_overflow_set", 88'(st), 88'(32'h0000_100D));
    bus_write(BASE + 32'd2, 32'hFF, 4'hF);
    read_status(st);
    check("base_plus2_write_ignored", 88'(st), 88'(32'h0000_100D));
    bus_write(BASE + 32'd1, 32'h8, 4'h2);
    read_status(st);
    check("clear_needs_mask0", 88'(st), 88'(32'h0000_100D));
    bus_write(BASE + 32'd1, 32'h8, 4'h1);
    read_status(st);
    check("overflow_cleared", 88'(st), 88'(32'h0000_1005));

    apply_reset();
    #1;

    // reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) bus_write(BASE, 32'h00, 4'h1);
    repeat (7) begin
      @(posedge clock);
      #1;
    end
    check("mid_frame_tx_low", 88'(tx), 88'(1'b0));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_tx_high", 88'(tx), 88'(1'b1));
    read_status(st);
    check("abort_status_empty", 88'(st), 88'(32'h2));
    @(negedge clock);
    reset = 1'b0;
    low_count = 0;
    repeat (200) begin
      @(posedge clock);
      #1;
      if (tx == 1'b0) low_count++;
    end
    check("no_frames_after_abort", 88'(low_count), 88'(0));
    read_status(st);
    check("status_after_abort_idle", 88'(st), 88'(32'h2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
